// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared definitions for the masked AES-128 round controller.
// Holds the FSM state encoding, the default round count, the RCON
// start value and the GF(2^8) xtime helper.
package mskaes_128bits_round_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_WAIT_RND = 3'd2;
  localparam logic [2:0] ST_ROUND    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_CLEAN    = 3'd5;

  localparam int         NROUNDS_DEF   = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mskaes_128bits_round_ctrl_if.sv
// Handshake bundle between the round controller and its neighbours.
//   in_valid/in_ready   : plaintext/key share load handshake
//   out_valid/out_ready : ciphertext share handshake
//   rnd_valid/rnd_req   : PRNG availability / randomness consumption
// slave  = the controller side, master = wrapper/PRNG side.
interface mskaes_128bits_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic rnd_valid;
  logic rnd_req;

  modport master (output in_valid, out_ready, rnd_valid,
                  input  in_ready, out_valid, rnd_req);
  modport slave  (input  in_valid, out_ready, rnd_valid,
                  output in_ready, out_valid, rnd_req);
endinterface

// File: rtl/mskaes_128bits_round_ctrl_rcon_gen.sv
// Plain (unmasked) AES round-constant generator.
//   clk, rst : clock, synchronous active-high reset (loads AES_RCON_INIT)
//   init     : reload AES_RCON_INIT
//   step     : advance rcon by one xtime
//   rcon     : current round constant
module mskaes_rcon_gen
  import mskaes_128bits_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       step,
  output logic [7:0] rcon
);

  always_ff @(posedge clk) begin
    if (rst || init) rcon <= AES_RCON_INIT;
    else if (step)   rcon <= xtime(rcon);
  end

endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Control FSM for the 128-bit masked AES round datapath: load, NROUNDS
// rounds of LATENCY cycles (each gated on fresh randomness), output
// handshake, then a LATENCY+1 cycle cleaning pass that flushes key shares.
//   clk, rst    : clock, synchronous active-high reset
//   hs          : in/out/randomness handshakes (slave side)
//   sel_init    : registers load from input
//   sel_last    : final round (SR output feeds state, no MC)
//   state_en    : state share register enable
//   key_en      : key share register enable
//   cleaning_on : datapath cleaning mode
//   rcon        : plain round constant for the current round
//   round       : current round, 0 = idle/load
//   busy        : controller not idle
module mskaes_128bits_round_ctrl
  import mskaes_128bits_round_ctrl_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int NROUNDS = NROUNDS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  mskaes_128bits_round_ctrl_if.slave hs,
  output logic                       sel_init,
  output logic                       sel_last,
  output logic                       state_en,
  output logic                       key_en,
  output logic                       cleaning_on,
  output logic [7:0]                 rcon,
  output logic [3:0]                 round,
  output logic                       busy
);

  localparam int CW = $clog2(LATENCY + 2);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_rnd, last_cyc, clean_end, rcon_step;

  assign last_rnd  = (round == 4'(NROUNDS));
  // Round registers capture on the final pipeline cycle of a pass.
  assign last_cyc  = (state == ST_ROUND) && (cnt == CW'(LATENCY - 1));
  assign clean_end = (state == ST_CLEAN) && (cnt == CW'(LATENCY));
  // The final round keeps its rcon/round; they reset when cleaning ends.
  assign rcon_step = last_cyc && !last_rnd;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (hs.in_valid)  state_nxt = ST_LOAD;
      ST_LOAD:                       state_nxt = ST_WAIT_RND;
      ST_WAIT_RND: if (hs.rnd_valid) state_nxt = ST_ROUND;
      ST_ROUND:    if (last_cyc)     state_nxt = last_rnd ? ST_DONE : ST_WAIT_RND;
      ST_DONE:     if (hs.out_ready) state_nxt = ST_CLEAN;
      ST_CLEAN:    if (clean_end)    state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      round <= '0;
    end else begin
      state <= state_nxt;
      // Counter runs only inside ROUND/CLEAN and is cleared on their exit,
      // so it is already zero on every entry.
      if ((state == ST_ROUND && !last_cyc) || (state == ST_CLEAN && !clean_end))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (state == ST_LOAD) round <= 4'd1;
      else if (rcon_step)   round <= round + 4'd1;
      else if (clean_end)   round <= '0;
    end
  end

  mskaes_rcon_gen u_rcon (
    .clk  (clk),
    .rst  (rst),
    .init ((state == ST_LOAD) || clean_end),
    .step (rcon_step),
    .rcon (rcon)
  );

  assign hs.in_ready  = (state == ST_IDLE);
  assign hs.out_valid = (state == ST_DONE);
  assign hs.rnd_req   = (state == ST_ROUND) || (state == ST_CLEAN);
  assign sel_init     = (state == ST_LOAD);
  assign sel_last     = (state == ST_ROUND) && last_rnd;
  assign state_en     = (state == ST_LOAD) || last_cyc || (state == ST_CLEAN);
  assign key_en       = state_en;
  assign cleaning_on  = (state == ST_CLEAN);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Bench for the masked AES-128 round controller (LATENCY=4, NROUNDS=10).
// Expected per-cycle outputs come from a schedule model: given the input
// streams it computes the cycle spans of load, each round, done and clean,
// and paints the expected outputs over those spans.
module tb_mskaes_128bits_round_ctrl;

  localparam int L  = 4;
  localparam int NR = 10;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_init, sel_last, state_en, key_en, cleaning_on, busy;
  logic [7:0] rcon;
  logic [3:0] round;

  mskaes_128bits_round_ctrl_if hs();

  mskaes_128bits_round_ctrl #(.LATENCY(L), .NROUNDS(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs),
    .sel_init    (sel_init),
    .sel_last    (sel_last),
    .state_en    (state_en),
    .key_en      (key_en),
    .cleaning_on (cleaning_on),
    .rcon        (rcon),
    .round       (round),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rtab [0:10];
  logic [20:0] exp_v [0:MAXC-1];
  bit          iv_a [0:MAXC-1];
  bit          rv_a [0:MAXC-1];
  bit          or_a [0:MAXC-1];

  // {in_ready,out_valid,rnd_req,sel_init,sel_last,state_en,key_en,cleaning_on,busy,rcon,round}
  function automatic logic [20:0] mk(input logic ir, ov, rr, si, sl, se, ke, co, bz,
                                     input logic [7:0] rc, input logic [3:0] rd);
    return {ir, ov, rr, si, sl, se, ke, co, bz, rc, rd};
  endfunction

  function automatic logic [20:0] get_out();
    return {hs.in_ready, hs.out_valid, hs.rnd_req, sel_init, sel_last, state_en,
            key_en, cleaning_on, busy, rcon, round};
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
    end
  endtask

  task automatic put(input int c, input logic [20:0] v, input int n);
    if (c >= 0 && c < n) exp_v[c] = v;
  endtask

  // Schedule model: walks the input streams and marks phase spans.
  task automatic build(input int n);
    int i, a, t, ws, rs, dn, d;
    for (int c = 0; c < n; c++) exp_v[c] = mk(1,0,0,0,0,0,0,0,0, 8'h01, 4'd0);
    i = 0;
    while (i < n) begin
      if (!iv_a[i]) begin i++; continue; end
      a = i;
      put(a + 1, mk(0,0,0,1,0,1,1,0,1, 8'h01, 4'd0), n);
      t = a + 2;
      for (int r = 1; r <= NR; r++) begin
        ws = t;
        while (t < n && !rv_a[t]) t++;
        rs = t + 1;
        for (int c = ws; c < rs; c++) put(c, mk(0,0,0,0,0,0,0,0,1, rtab[r], 4'(r)), n);
        for (int k = 0; k < L; k++)
          put(rs + k, mk(0,0,1,0, r == NR, k == L-1, k == L-1, 0,1, rtab[r], 4'(r)), n);
        t = rs + L;
      end
      dn = t;
      d  = t;
      while (d < n && !or_a[d]) d++;
      for (int c = dn; c <= d; c++) put(c, mk(0,1,0,0,0,0,0,0,1, rtab[NR], 4'(NR)), n);
      for (int c = d + 1; c <= d + L + 1; c++) put(c, mk(0,0,1,0,0,1,1,1,1, rtab[NR], 4'(NR)), n);
      i = d + L + 2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hs.in_valid = 1'b0; hs.rnd_valid = 1'b0; hs.out_ready = 1'b0;
    @(posedge clk);
  endtask

  // Drives the stored streams and compares every cycle against the model.
  task automatic run_sched(input string nm, input int n, output int first_ov, output int se_cnt);
    build(n);
    do_reset();
    first_ov = -1;
    se_cnt   = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = 1'b0;
      chk(nm, c, 32'(get_out()), 32'(exp_v[c]));
      if (hs.out_valid && first_ov < 0) first_ov = c;
      if (state_en && first_ov < 0) se_cnt++;
      hs.in_valid  = iv_a[c];
      hs.rnd_valid = rv_a[c];
      hs.out_ready = or_a[c];
    end
  endtask

  typedef struct {
    logic        iv, rv, ordy;
    int          n;
    logic [20:0] want;
  } vec_t;

  vec_t vt [0:7];

  initial begin
    int fo, sec, k, m;
    rtab = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    hs.in_valid = 1'b0; hs.rnd_valid = 1'b0; hs.out_ready = 1'b0;

    // Directed table: start of a run, including a randomness stall.
    vt[0] = '{1'b0, 1'b0, 1'b0, 2, mk(1,0,0,0,0,0,0,0,0, 8'h01, 4'd0)};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1, mk(0,0,0,1,0,1,1,0,1, 8'h01, 4'd0)};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1, mk(0,0,0,0,0,0,0,0,1, 8'h01, 4'd1)};
    vt[3] = '{1'b1, 1'b0, 1'b0, 5, mk(0,0,0,0,0,0,0,0,1, 8'h01, 4'd1)};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1, mk(0,0,1,0,0,0,0,0,1, 8'h01, 4'd1)};
    vt[5] = '{1'b0, 1'b0, 1'b0, 3, mk(0,0,1,0,0,1,1,0,1, 8'h01, 4'd1)};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1, mk(0,0,0,0,0,0,0,0,1, 8'h02, 4'd2)};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1, mk(0,0,1,0,0,0,0,0,1, 8'h02, 4'd2)};
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      hs.in_valid = vt[v].iv; hs.rnd_valid = vt[v].rv; hs.out_ready = vt[v].ordy;
      repeat (vt[v].n) @(posedge clk);
      @(negedge clk);
      chk("table", v, 32'(get_out()), 32'(vt[v].want));
    end

    // Stall 7 cycles before round 3, hold DONE 20 cycles, in_valid stuck high.
    for (int c = 0; c < 100; c++) begin
      iv_a[c] = (c < 90);
      rv_a[c] = !(c >= 12 && c <= 18);
      or_a[c] = (c == 79);
    end
    run_sched("stall_hold", 100, fo, sec);
    chk("latency_stall", 0, 32'(fo), 32'(1 + 51 + 7));
    chk("state_en_pulses", 0, 32'(sec), 32'd11);

    // Randomized streams.
    for (int c = 0; c < 1500; c++) begin
      iv_a[c] = ($urandom_range(0, 1) == 1);
      rv_a[c] = ($urandom_range(0, 9) < 7);
      or_a[c] = ($urandom_range(0, 1) == 1);
    end
    run_sched("random", 1500, fo, sec);

    // Reset during round 6, cycle 2, then a clean run.
    do_reset();
    @(negedge clk);
    rst = 1'b0; hs.in_valid = 1'b1; hs.rnd_valid = 1'b1; hs.out_ready = 1'b0;
    @(negedge clk);
    hs.in_valid = 1'b0;
    k = 0;
    while (!(round == 4'd6 && hs.rnd_req) && k < 300) begin @(negedge clk); k++; end
    chk("reach_round6", k, 32'(k < 300), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", 0, 32'(get_out()), 32'(mk(1,0,0,0,0,0,0,0,0, 8'h01, 4'd0)));
    rst = 1'b0; hs.in_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); hs.in_valid = 1'b0; k++; end while (!hs.out_valid && k < 200);
    chk("rerun_latency", 0, 32'(k), 32'd52);
    chk("rerun_rcon", 0, 32'(rcon), 32'h36);
    hs.out_ready = 1'b1;
    @(negedge clk);
    hs.out_ready = 1'b0;
    m = 0;
    while (cleaning_on && m < 20) begin m++; @(negedge clk); end
    chk("clean_len", 0, 32'(m), 32'(L + 1));
    chk("idle_after", 0, 32'({hs.in_ready, busy, round, rcon}), 32'({1'b1, 1'b0, 4'd0, 8'h01}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
